bkm_slot_initiator: RTL and testbench

BKM_SLOT_INITIATOR -- requirements
Module: bkm_slot_initiator

---
 rtl/bkm_slot_initiator.sv | 150 +++++++++++++++
 tb/tb_bkm_slot_initiator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_slot_initiator.sv
`default_nettype none
// ============================================================================
// Module      : bkm_slot_initiator
// Description : Slot bus initiator; address + data phase strobe sequencer
//               with a synchronized, edge-triggered card interrupt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bkm_slot_initiator #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 2
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       slot_x_int_x,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  input  logic       irq_x,
  output logic       irq_pending,
  input  logic       irq_ack
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SETUP  = 4'd1,
    A_STROBE = 4'd2,
    A_HOLD   = 4'd3,
    D_SETUP  = 4'd4,
    D_STROBE = 4'd5,
    D_HOLD   = 4'd6,
    DONE     = 4'd7
  } state_t;

  localparam logic [3:0] c_SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] c_HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_rw;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_irq_s1;
  logic       r_irq_s2;
  logic       r_irq_s3;

  logic       w_accept;
  logic       w_rw;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_a_phase;
  logic       w_d_phase;
  logic       w_strobe;
  logic       w_sample;
  logic       w_irq_fall;

  // Pins are registered from the next state, so they move on the same edge
  // as the state; the command fields are bypassed on the accepting edge.
  always_comb begin
    w_accept   = (r_state == IDLE) && cmd_ready && cmd_valid;
    w_rw       = w_accept ? cmd_rw    : r_rw;
    w_addr     = w_accept ? cmd_addr  : r_addr;
    w_wdata    = w_accept ? cmd_wdata : r_wdata;
    w_next     = r_state;
    w_cnt_next = (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
    case (r_state)
      IDLE:     if (w_accept)       begin w_next = A_SETUP;  w_cnt_next = c_SETUP_LD;  end
      A_SETUP:  if (r_cnt == 4'd0)  begin w_next = A_STROBE; w_cnt_next = c_STROBE_LD; end
      A_STROBE: if (r_cnt == 4'd0)  begin w_next = A_HOLD;   w_cnt_next = c_HOLD_LD;   end
      A_HOLD:   if (r_cnt == 4'd0)  begin w_next = D_SETUP;  w_cnt_next = c_SETUP_LD;  end
      D_SETUP:  if (r_cnt == 4'd0)  begin w_next = D_STROBE; w_cnt_next = c_STROBE_LD; end
      D_STROBE: if (r_cnt == 4'd0)  begin w_next = D_HOLD;   w_cnt_next = c_HOLD_LD;   end
      D_HOLD:   if (r_cnt == 4'd0)  begin w_next = DONE;     w_cnt_next = 4'd0;        end
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    w_a_phase  = (w_next == A_SETUP) || (w_next == A_STROBE) || (w_next == A_HOLD);
    w_d_phase  = (w_next == D_SETUP) || (w_next == D_STROBE) || (w_next == D_HOLD);
    w_strobe   = (w_next == A_STROBE) || (w_next == D_STROBE);
    w_sample   = (r_state == D_STROBE) && (r_cnt == 4'd0) && r_rw;
    w_irq_fall = r_irq_s3 && !r_irq_s2;
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (!reset_x) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_rw         <= 1'b1;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      slot_x_int_x <= 1'b1;
      clk_rw       <= 1'b1;
      ax_d         <= 1'b1;
      r_wx         <= 1'b1;
      ad_out       <= 8'h00;
      ad_oe        <= 1'b0;
      r_irq_s1     <= 1'b1;
      r_irq_s2     <= 1'b1;
      r_irq_s3     <= 1'b1;
      irq_pending  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rw    <= cmd_rw;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      cmd_ready    <= (w_next == IDLE);
      rsp_valid    <= (r_state == DONE);
      if (w_sample) begin
        rsp_rdata <= ad_in;
      end
      slot_x_int_x <= !(w_a_phase || w_d_phase);
      clk_rw       <= !w_strobe;
      ax_d         <= !w_a_phase;
      r_wx         <= (w_next == IDLE) ? 1'b1 : w_rw;
      // Read data phases release the bus on the same edge the phase begins.
      ad_oe        <= w_a_phase || (w_d_phase && !w_rw);
      ad_out       <= w_a_phase ? w_addr : ((w_d_phase && !w_rw) ? w_wdata : 8'h00);
      r_irq_s1     <= irq_x;
      r_irq_s2     <= r_irq_s1;
      r_irq_s3     <= r_irq_s2;
      // A new falling edge wins over a coincident acknowledge.
      if (w_irq_fall) begin
        irq_pending <= 1'b1;
      end else if (irq_ack) begin
        irq_pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bkm_slot_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bkm_slot_initiator
// Description : Self-checking bench for bkm_slot_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bkm_slot_initiator;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_x, cmd_valid, cmd_ready, cmd_rw, rsp_valid;
  logic [7:0] cmd_addr, cmd_wdata, rsp_rdata, ad_out, ad_in;
  logic       slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe, irq_x, irq_pending, irq_ack;

  logic       cmd_valid_b, cmd_ready_b, cmd_rw_b, rsp_valid_b;
  logic [7:0] cmd_addr_b, cmd_wdata_b, rsp_rdata_b, ad_out_b, ad_in_b;
  logic       slot_b, clk_rw_b, ax_d_b, r_wx_b, ad_oe_b, irq_pending_b;

  bkm_slot_initiator dut_a (
    .clk_50mhz_in(clk), .reset_x(reset_x),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .slot_x_int_x(slot_x_int_x), .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .irq_x(irq_x), .irq_pending(irq_pending), .irq_ack(irq_ack)
  );

  bkm_slot_initiator #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_b (
    .clk_50mhz_in(clk), .reset_x(reset_x),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_rw(cmd_rw_b),
    .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .slot_x_int_x(slot_b), .clk_rw(clk_rw_b), .ax_d(ax_d_b), .r_wx(r_wx_b),
    .ad_out(ad_out_b), .ad_oe(ad_oe_b), .ad_in(ad_in_b),
    .irq_x(1'b1), .irq_pending(irq_pending_b), .irq_ack(1'b0)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_count = 0;
  int last_rsp_cyc = 0;
  int last_acc = 0;
  bit mon_en = 1'b0;
  logic [7:0] last_rd = 8'h00;
  vec_t exp_q[$];
  int   acc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected {mask, value} of {slot, clk_rw, ax_d, r_wx, ad_oe, ad_out}
  // at cycle j after the accepting edge.
  function automatic logic [25:0] exp_pins(input int j, input int s, input int t, input int h,
                                           input logic rw, input logic [7:0] a, input logic [7:0] w);
    int p, k;
    logic st;
    p = s + t + h;
    if (j < p) begin
      st = (j >= s) && (j < s + t);
      return {13'h1FFF, 1'b0, ~st, 1'b0, rw, 1'b1, a};
    end else if (j < 2 * p) begin
      k  = j - p;
      st = (k >= s) && (k < s + t);
      return {5'h1F, (rw ? 8'h00 : 8'hFF), 1'b0, ~st, 1'b1, rw, ~rw, (rw ? 8'h00 : w)};
    end
    return {13'b1100100000000, 13'b1100000000000};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset_x) begin
      acc_q.delete();
      exp_q.delete();
      last_rd = 8'h00;
    end else if (cmd_valid && cmd_ready) begin
      acc_q.push_back(cyc);
      last_acc = cyc;
    end
  end

  int jm;
  logic [25:0] em;
  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_q.size() != 0) begin
        jm = cyc - acc_q[0];
        if (rsp_valid) begin
          chk("latency", jm, 25);
          chk("ready_at_rsp", cmd_ready, 1);
          if (exp_q[0].rw) begin
            chk("rdata", rsp_rdata, exp_q[0].rdata);
            last_rd = exp_q[0].rdata;
          end else begin
            chk("rdata_hold", rsp_rdata, last_rd);
          end
          rsp_count++;
          last_rsp_cyc = cyc;
          void'(acc_q.pop_front());
          void'(exp_q.pop_front());
        end else if (jm > 25) begin
          chk("rsp_timeout", jm, 25);
          void'(acc_q.pop_front());
          void'(exp_q.pop_front());
        end else begin
          em = exp_pins(jm, 2, 8, 2, exp_q[0].rw, exp_q[0].addr, exp_q[0].wdata);
          chk("pins", {19'd0, {slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe, ad_out} & em[25:13]},
              {19'd0, em[12:0]});
          chk("ready_busy", cmd_ready, 0);
        end
      end else begin
        chk("stray_rsp", rsp_valid, 0);
        chk("idle_pins", {slot_x_int_x, clk_rw, ad_oe}, 3'b110);
      end
      ad_in = (!clk_rw && ax_d && exp_q.size() != 0) ? exp_q[0].rdata : 8'hEE;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    for (int k = 0; k < 50 && !cmd_ready; k++) step();
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
    exp_q.push_back(v);
    step();
    for (int k = 0; k < 5 && acc_q.size() == 0; k++) step();
    chk("accept", acc_q.size(), 1);
    cmd_valid = 1'b0;
    for (int k = 0; k < 40 && acc_q.size() != 0; k++) step();
    chk("complete", acc_q.size(), 0);
  endtask

  vec_t tbl[6];
  vec_t v1, v2;
  int rc0;

  initial begin
    tbl[0] = '{rw: 1'b0, addr: 8'h12, wdata: 8'hA5, rdata: 8'hC3};
    tbl[1] = '{rw: 1'b1, addr: 8'h03, wdata: 8'h00, rdata: 8'h5C};
    tbl[2] = '{rw: 1'b0, addr: 8'hFF, wdata: 8'h00, rdata: 8'h3A};
    tbl[3] = '{rw: 1'b1, addr: 8'h00, wdata: 8'h77, rdata: 8'hFF};
    tbl[4] = '{rw: 1'b0, addr: 8'h80, wdata: 8'h5A, rdata: 8'h11};
    tbl[5] = '{rw: 1'b1, addr: 8'h7E, wdata: 8'hFF, rdata: 8'h81};

    reset_x = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    ad_in = 8'hEE; irq_x = 1'b1; irq_ack = 1'b0;
    cmd_valid_b = 1'b0; cmd_rw_b = 1'b0; cmd_addr_b = 8'h00; cmd_wdata_b = 8'h00; ad_in_b = 8'hEE;
    step(); step();
    chk("reset_state",
        {slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe, cmd_ready, rsp_valid, rsp_rdata, irq_pending},
        {1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    mon_en = 1'b1;
    reset_x = 1'b1;
    step();
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // Back-to-back with cmd_valid held high.
    v1 = '{rw: 1'b0, addr: 8'h21, wdata: 8'h96, rdata: 8'h00};
    v2 = '{rw: 1'b1, addr: 8'h42, wdata: 8'h00, rdata: 8'hB7};
    cmd_valid = 1'b1; cmd_rw = v1.rw; cmd_addr = v1.addr; cmd_wdata = v1.wdata;
    exp_q.push_back(v1); exp_q.push_back(v2);
    rc0 = rsp_count;
    step();
    chk("b2b_accept1", acc_q.size(), 1);
    cmd_rw = v2.rw; cmd_addr = v2.addr; cmd_wdata = v2.wdata;
    for (int k = 0; k < 40 && rsp_count == rc0; k++) step();
    step();
    chk("b2b_accept2", acc_q.size(), 1);
    chk("b2b_gap", last_acc - last_rsp_cyc, 1);
    cmd_valid = 1'b0;
    for (int k = 0; k < 40 && acc_q.size() != 0; k++) step();
    chk("b2b_complete", rsp_count - rc0, 2);

    // Reset during D_STROBE.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h5E; cmd_wdata = 8'hE5;
    exp_q.push_back('{rw: 1'b0, addr: 8'h5E, wdata: 8'hE5, rdata: 8'h00});
    step();
    chk("rst_accept", acc_q.size(), 1);
    cmd_valid = 1'b0;
    repeat (15) step();
    chk("in_d_strobe", {clk_rw, ax_d}, 2'b01);
    rc0 = rsp_count;
    reset_x = 1'b0;
    step();
    chk("rst_pins", {slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe, cmd_ready, rsp_valid},
        {4'b1111, 8'h00, 3'b000});
    reset_x = 1'b1;
    step();
    chk("rst_ready", cmd_ready, 1);
    repeat (30) step();
    chk("rst_no_rsp", rsp_count, rc0);

    // Interrupt flag.
    irq_x = 1'b0;
    step(); step();
    chk("irq_not_yet", irq_pending, 0);
    step();
    chk("irq_set", irq_pending, 1);
    irq_x = 1'b1;
    repeat (4) step();
    irq_x = 1'b0;
    step(); step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_ack_vs_set", irq_pending, 1);
    repeat (3) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_cleared", irq_pending, 0);
    repeat (5) step();
    chk("irq_level_no_reset", irq_pending, 0);

    // Minimum-length phases on the second instance.
    chk("b_ready", cmd_ready_b, 1);
    cmd_valid_b = 1'b1; cmd_rw_b = 1'b1; cmd_addr_b = 8'h44; cmd_wdata_b = 8'h99;
    step();
    chk("b_accept", cmd_ready_b, 0);
    cmd_valid_b = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j < 7) begin
        em = exp_pins(j, 1, 1, 1, 1'b1, 8'h44, 8'h99);
        chk("b_pins", {19'd0, {slot_b, clk_rw_b, ax_d_b, r_wx_b, ad_oe_b, ad_out_b} & em[25:13]},
            {19'd0, em[12:0]});
        chk("b_no_rsp", rsp_valid_b, 0);
        ad_in_b = (j == 4) ? 8'h3C : 8'hEE;
      end else begin
        chk("b_rsp", rsp_valid_b, 1);
        chk("b_rdata", rsp_rdata_b, 8'h3C);
      end
      step();
    end
    chk("b_rsp_pulse", rsp_valid_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
